xbar_wt_mem_pingpong: RTL

Double-buffered crossbar weight store with parametrised crossbar size, weight width and bank count of two, one active and one shadow. The MVM datapath reads the active bank, by row or by column, with one cycle of latency. Meanwhile the shadow bank is loaded row by row over a valid/ready stream. A swap request exchanges the banks only when the shadow bank is fully loaded, so reprogramming the crossbar never stalls the read path.

---
 rtl/xbar_wt_mem_pingpong.sv | 131 +++++++++++++
 1 files changed

// File: rtl/xbar_wt_mem_pingpong.sv
// Double-buffered crossbar weight store: the read port serves the active bank
// while the shadow bank is reloaded row by row, and a swap exchanges the banks.
module xbar_wt_mem_pingpong #(
  parameter  int XBAR_SIZE = 16,
  parameter  int WT_BITS   = 16,
  localparam int ADDR_W    = $clog2(XBAR_SIZE),
  localparam int ROW_W     = XBAR_SIZE * WT_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [ROW_W-1:0]  prog_row_data,
  output logic              prog_done,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              active_bank,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_col_mode,
  output logic              rd_valid,
  output logic [ROW_W-1:0]  rd_weight_v
);

  typedef enum logic [1:0] {SH_EMPTY, SH_LOADING, SH_FULL} shadow_state_e;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(XBAR_SIZE - 1);

  logic [ROW_W-1:0] mem_q [2][XBAR_SIZE];
  logic [ROW_W-1:0] mem_d [2][XBAR_SIZE];
  shadow_state_e    state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             active_q, active_d;
  logic             prog_ready_q, prog_ready_d;
  logic             prog_done_q, prog_done_d;
  logic             swap_ack_q, swap_ack_d;
  logic             rd_valid_q, rd_valid_d;
  logic [ROW_W-1:0] rd_data_q, rd_data_d;
  logic [ROW_W-1:0] col_data;
  logic             beat;
  logic             do_swap;

  // Beats and swaps are mutually exclusive: prog_ready is low exactly while FULL.
  assign beat    = prog_valid && prog_ready_q;
  assign do_swap = swap_req && (state_q == SH_FULL);

  // Transpose read: element k of the column comes from row k of the active bank.
  always_comb begin
    col_data = '0;
    for (int k = 0; k < XBAR_SIZE; k++) begin
      col_data[k*WT_BITS +: WT_BITS] = mem_q[active_q][k][int'(rd_addr)*WT_BITS +: WT_BITS];
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    mem_d       = mem_q;
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    active_d    = active_q;
    prog_done_d = 1'b0;
    swap_ack_d  = 1'b0;
    rd_valid_d  = rd_en;
    rd_data_d   = rd_data_q;

    if (beat) begin
      mem_d[~active_q][wr_ptr_q] = prog_row_data;
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      state_d  = SH_LOADING;
      if (wr_ptr_q == LAST_ROW) begin
        state_d     = SH_FULL;
        prog_done_d = 1'b1;
      end
    end

    if (do_swap) begin
      active_d   = ~active_q;
      state_d    = SH_EMPTY;
      wr_ptr_d   = '0;
      swap_ack_d = 1'b1;
    end

    prog_ready_d = (state_d != SH_FULL);

    // Reads use the bank active before this edge, unaffected by a coincident swap.
    if (rd_en) begin
      rd_data_d = rd_col_mode ? col_data : mem_q[active_q][rd_addr];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the weight array is cleared on reset because reads of an
      // unprogrammed bank must return zero, which rules out plain RAM macros.
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < XBAR_SIZE; r++) begin
          mem_q[b][r] <= '0;
        end
      end
      state_q      <= SH_EMPTY;
      wr_ptr_q     <= '0;
      active_q     <= 1'b0;
      prog_ready_q <= 1'b0;
      prog_done_q  <= 1'b0;
      swap_ack_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      mem_q        <= mem_d;
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      active_q     <= active_d;
      prog_ready_q <= prog_ready_d;
      prog_done_q  <= prog_done_d;
      swap_ack_q   <= swap_ack_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign prog_ready  = prog_ready_q;
  assign prog_done   = prog_done_q;
  assign swap_ack    = swap_ack_q;
  assign active_bank = active_q;
  assign rd_valid    = rd_valid_q;
  assign rd_weight_v = rd_data_q;

endmodule
